openhw_ram2p_ctrl: RTL

OPENHW_RAM2P_CTRL -- requirements
Module: openhw_ram2p_ctrl

---
 rtl/openhw_ram2p_ctrl_pkg.sv | 18 +
 rtl/openhw_rrarb2.sv | 32 +++
 rtl/openhw_ram2p_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/openhw_ram2p_ctrl_pkg.sv
// Shared types and constants for the two-port RAM controller.
// The optional write-to-read forwarding path is enabled with RAM2P_CTRL_FWD_EN.
package openhw_ram2p_ctrl_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  typedef enum logic {
    REQ_FILL  = 1'b0,
    REQ_STORE = 1'b1
  } req_idx_e;

  // Byte-enable lane count; the last lane may be narrower than 8 bits.
  function automatic int calc_bw(input int width);
    return (width - 1) / 8 + 1;
  endfunction

endpackage

// File: rtl/openhw_rrarb2.sv
// Two-requester round-robin arbiter. The pointer moves only after a contested
// grant, so an uncontested requester never steals the other's next turn.
module openhw_rrarb2
  import openhw_ram2p_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_reg;
  logic ptr_next;

  always_comb begin
    gnt      = req;
    ptr_next = ptr_reg;
    if (req == 2'b11) begin
      gnt      = (ptr_reg == REQ_STORE) ? 2'b10 : 2'b01;
      ptr_next = ~ptr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= REQ_FILL;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/openhw_ram2p_ctrl.sv
// Controller for a read-first two-port RAM: power-up/on-demand clear sequence,
// two-requester write arbitration and single-cycle reads. Option: RAM2P_CTRL_FWD_EN.
module openhw_ram2p_ctrl
  import openhw_ram2p_ctrl_pkg::*;
#(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 68,
  localparam int AW    = $clog2(DEPTH),
  localparam int BW    = calc_bw(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  output logic               busy,
  input  logic               rvalid,
  input  logic [AW-1:0]      raddr,
  output logic               rdvalid,
  output logic [WIDTH-1:0]   rdata,
  input  logic [1:0]         wvalid,
  output logic [1:0]         wready,
  input  logic [2*AW-1:0]    waddr,
  input  logic [2*WIDTH-1:0] wdata,
  input  logic [2*BW-1:0]    wbwe,
  output logic               ce1,
  output logic [AW-1:0]      ra1,
  output logic               ce2,
  output logic               we2,
  output logic [AW-1:0]      wa2,
  output logic [WIDTH-1:0]   wd2,
  output logic [BW-1:0]      bwe2,
  input  logic [WIDTH-1:0]   rd1
);

  logic [0:0]    state_reg;
  logic [AW-1:0] cnt_reg;
  logic          rdvalid_reg;
  logic [1:0]    arb_req;
  logic [1:0]    arb_gnt;
  logic          win;

  // Requests are masked while clearing so the arbiter pointer cannot move.
  assign arb_req = (state_reg == ST_IDLE) ? wvalid : 2'b00;
  assign win     = arb_gnt[1];

  openhw_rrarb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (arb_req),
    .gnt   (arb_gnt)
  );

  always_comb begin
    busy   = 1'b0;
    wready = 2'b00;
    ce1    = 1'b0;
    ra1    = raddr;
    ce2    = 1'b0;
    we2    = 1'b0;
    wa2    = '0;
    wd2    = '0;
    bwe2   = '0;
    if (state_reg == ST_CLEAR) begin
      busy = 1'b1;
      ce2  = 1'b1;
      we2  = 1'b1;
      wa2  = cnt_reg;
      bwe2 = '1;
    end else begin
      ce1    = rvalid;
      wready = arb_gnt;
      if (|arb_gnt) begin
        ce2  = 1'b1;
        we2  = 1'b1;
        wa2  = win ? waddr[2*AW-1:AW]       : waddr[AW-1:0];
        wd2  = win ? wdata[2*WIDTH-1:WIDTH] : wdata[WIDTH-1:0];
        bwe2 = win ? wbwe[2*BW-1:BW]        : wbwe[BW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_CLEAR;
      cnt_reg     <= '0;
      rdvalid_reg <= 1'b0;
    end else begin
      rdvalid_reg <= ce1;
      if (clr) begin
        state_reg <= ST_CLEAR;
        cnt_reg   <= '0;
      end else if (state_reg == ST_CLEAR) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == AW'(DEPTH - 1)) begin
          state_reg <= ST_IDLE;
        end
      end
    end
  end

  assign rdvalid = rdvalid_reg;

`ifdef RAM2P_CTRL_FWD_EN
  logic             fwd_hit_reg;
  logic [WIDTH-1:0] fwd_data_reg;
  logic [BW-1:0]    fwd_bwe_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_hit_reg  <= 1'b0;
      fwd_data_reg <= '0;
      fwd_bwe_reg  <= '0;
    end else begin
      fwd_hit_reg  <= ce1 && we2 && (ra1 == wa2);
      fwd_data_reg <= wd2;
      fwd_bwe_reg  <= bwe2;
    end
  end

  // Per-lane merge of the colliding write over the RAM's old data.
  for (genvar gi = 0; gi < BW; gi++) begin : g_fwd_lane
    localparam int LO = gi * 8;
    localparam int HI = (gi * 8 + 7 < WIDTH) ? gi * 8 + 7 : WIDTH - 1;
    assign rdata[HI:LO] = (fwd_hit_reg && fwd_bwe_reg[gi]) ? fwd_data_reg[HI:LO] : rd1[HI:LO];
  end
`else
  assign rdata = rd1;
`endif

endmodule
